apb_slave_regfile: RTL and testbench

- APB completer (responder) block: the far end of the NOC's per-slave APB master port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB in; PRDATA/PREADY/PSLVERR out).
- Implements a bank of 32-bit registers with byte strobes, programmable wait states and error signalling.
- Serves as the stand-in APB slave behind the NOC slave ports in the verification environment.
- Also used as a generic control/status register target.

---
 rtl/apb_slave_regfile.sv | 90 +++++++++
 tb/tb_apb_slave_regfile.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a byte-strobed 32-bit register bank, programmable wait states and error response.
// Register 0 is a read-only ID; PREADY/PSLVERR/PRDATA are decoded only from registered state.
module apb_slave_regfile #(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h5333_0001
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ASW_RESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);
  localparam int          IW   = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN = 32'(4 * NUM_REGS);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [31:0] r_addr, r_wdata;
  logic [3:0]  r_strb;
  logic        r_write;
  logic [31:0] r_regs [NUM_REGS];
  logic        w_latch, w_done, w_err;
  logic [31:0] w_off;
  logic [IW-1:0] w_idx;
  // Offset arithmetic avoids overflow when BASE_ADDR sits near the top of the address map
  assign w_off   = r_addr - BASE_ADDR;
  assign w_idx   = w_off[IW+1:2];
  assign w_err   = (r_addr < BASE_ADDR) || (w_off >= SPAN) || (r_addr[1:0] != 2'b00) ||
                   (r_write && w_idx == '0);
  assign PREADY  = (r_state == ACCESS) && (r_cnt == 4'd0);
  assign PSLVERR = PREADY && w_err;
  assign PRDATA  = (PREADY && !w_err && !r_write) ? ((w_idx == '0) ? ID_VALUE : r_regs[w_idx]) : 32'h0;
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_latch     = 1'b0;
    w_done      = 1'b0;
    if (r_state == IDLE) begin
      if (PSEL && !PENABLE) begin
        w_state_nxt = ACCESS;
        w_cnt_nxt   = 4'(WAIT_CYCLES);
        w_latch     = 1'b1;
      end
    end else if (!PSEL) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 4'd0;
    end else if (PENABLE) begin
      if (r_cnt != 4'd0) w_cnt_nxt = r_cnt - 4'd1;
      else begin
        w_state_nxt = IDLE;
        w_done      = 1'b1;
      end
    end
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (ASW_RESET) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_done && r_write && !w_err)
        for (int b = 0; b < 4; b++)
          if (r_strb[b]) r_regs[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end
  // Setup-phase capture only; later changes on the bus are ignored until the next setup
  always_ff @(posedge ACLK) begin
    if (w_latch) begin
      r_addr  <= PADDR;
      r_wdata <= PWDATA;
      r_strb  <= PSTRB;
      r_write <= PWRITE;
    end
  end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: three register-file instances (0, 2 and 3 wait states, one with a non-zero base)
// driven by an APB master task and checked against a byte-array register model.
module tb_apb_slave_regfile;
  localparam logic [31:0] ID = 32'h5333_0001;
  logic        clk = 1'b0;
  logic        rst_n, sw_rst, penable, pwrite;
  logic [2:0]  psel;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata [3];
  logic        pready [3];
  logic        pslverr [3];
  logic [31:0] bases [3] = '{32'h0, 32'h0, 32'h0000_1000};
  int          waits [3] = '{0, 2, 3};
  logic [31:0] model [3][16];
  int          n_checks = 0, n_fail = 0, err_in_wait = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (
    .ACLK(clk), .ARESETn(rst_n), .ASW_RESET(sw_rst), .PSEL(psel[0]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
  apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u1 (
    .ACLK(clk), .ARESETn(rst_n), .ASW_RESET(sw_rst), .PSEL(psel[1]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
  apb_slave_regfile #(.NUM_REGS(16), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(3)) u2 (
    .ACLK(clk), .ARESETn(rst_n), .ASW_RESET(sw_rst), .PSEL(psel[2]), .PENABLE(penable),
    .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
    .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

  function automatic logic exp_err(int d, bit wr, logic [31:0] a);
    logic [31:0] off;
    off = a - bases[d];
    return (a < bases[d]) || (off >= 32'd64) || (a[1:0] != 2'b00) || (wr && off < 32'd4);
  endfunction

  function automatic logic [31:0] exp_rd(int d, logic [31:0] a);
    logic [31:0] off;
    off = a - bases[d];
    if (exp_err(d, 1'b0, a)) return 32'h0;
    return (off < 32'd4) ? ID : model[d][off[5:2]];
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 3; d++) for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
  endtask

  task automatic idle();
    @(negedge clk);
    psel = 3'b000; penable = 1'b0;
  endtask

  // Leaves the bus asserted at the completion cycle so a following call is back-to-back
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er, output int nw);
    logic [31:0] off;
    @(negedge clk);
    psel = 3'(1 << d); penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(negedge clk);
    penable = 1'b1;
    nw = 0;
    while (!pready[d] && nw < 40) begin
      if (pslverr[d]) err_in_wait++;
      nw++;
      @(negedge clk);
    end
    rd = prdata[d]; er = pslverr[d];
    if (!pready[d]) begin
      n_checks++; n_fail++;
      $display("FAIL timeout dut%0d addr=%h: PREADY never rose", d, a);
    end else if (wr && !exp_err(d, 1'b1, a)) begin
      off = a - bases[d];
      for (int b = 0; b < 4; b++) if (st[b]) model[d][off[5:2]][8*b +: 8] = wd[8*b +: 8];
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int nw;
    rst_n = 1'b0; sw_rst = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    clear_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if ({prdata[d], pready[d], pslverr[d]} !== 34'h0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d got %h/%b/%b want 0/0/0", d, prdata[d], pready[d], pslverr[d]);
      end
    end
    rst_n = 1'b1;
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== ID || er !== 1'b0) begin n_fail++; $display("FAIL id_read got %h err=%b want %h err=0", rd, er, ID); end
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin n_fail++; $display("FAIL reg1_reset got %h err=%b want 0 err=0", rd, er); end
    xfer(2, 1'b0, 32'h1000, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== ID || er !== 1'b0) begin n_fail++; $display("FAIL id_read_base got %h err=%b want %h", rd, er, ID); end
    idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int nw;
    xfer(1, 1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, rd, er, nw);
    n_checks++;
    if (nw !== 2 || er !== 1'b0) begin n_fail++; $display("FAIL wait_write waits=%0d err=%b want 2/0", nw, er); end
    idle();
    xfer(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== 32'hDEAD_BEEF || nw !== 2) begin n_fail++; $display("FAIL wait_read got %h waits=%0d want deadbeef/2", rd, nw); end
    idle();
  endtask

  task automatic test_strobes();
    logic [31:0] rd; logic er; int nw;
    xfer(0, 1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF, rd, er, nw);
    xfer(0, 1'b1, 32'hC, 32'h1234_5678, 4'b0101, rd, er, nw);
    xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== 32'hFF34_FF78 || rd !== exp_rd(0, 32'hC)) begin n_fail++; $display("FAIL strobe_merge got %h want ff34ff78", rd); end
    xfer(0, 1'b1, 32'hC, 32'hAAAA_AAAA, 4'h0, rd, er, nw);
    n_checks++;
    if (er !== 1'b0) begin n_fail++; $display("FAIL strobe_zero_err got %b want 0", er); end
    xfer(0, 1'b0, 32'hC, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== 32'hFF34_FF78) begin n_fail++; $display("FAIL strobe_zero_hold got %h want ff34ff78", rd); end
    idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int nw;
    xfer(0, 1'b1, 32'h0, 32'h1111_1111, 4'hF, rd, er, nw);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL err_id_write got %b want 1", er); end
    xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== ID) begin n_fail++; $display("FAIL id_unchanged got %h want %h", rd, ID); end
    xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_range got %h err=%b want 0 err=1", rd, er); end
    xfer(0, 1'b1, 32'h6, 32'h7777_7777, 4'hF, rd, er, nw);
    n_checks++;
    if (er !== 1'b1) begin n_fail++; $display("FAIL err_misaligned got %b want 1", er); end
    xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL misaligned_nowrite got %h want 0", rd); end
    xfer(2, 1'b0, 32'h0FFC, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL err_below_base got %h err=%b want 0 err=1", rd, er); end
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int nw; int seen;
    seen = 0;
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1010; pwdata = 32'hA5A5_A5A5; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1;
    if (pready[2]) seen++;
    @(negedge clk);
    if (pready[2]) seen++;
    psel = 3'b000; penable = 1'b0;
    repeat (5) begin @(negedge clk); if (pready[2]) seen++; end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_ready got %0d ready cycles want 0", seen); end
    xfer(2, 1'b0, 32'h1010, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_nowrite got %h want 0", rd); end
    idle();
  endtask

  task automatic test_sw_reset();
    logic [31:0] rd; logic er; int nw;
    for (int i = 1; i < 16; i++) xfer(0, 1'b1, 32'(4 * i), $urandom, 4'hF, rd, er, nw);
    xfer(1, 1'b1, 32'h14, 32'h5555_0000, 4'hF, rd, er, nw);
    @(negedge clk);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 32'h1014; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    @(negedge clk);
    penable = 1'b1; sw_rst = 1'b1;
    @(negedge clk);
    sw_rst = 1'b0; psel = 3'b000; penable = 1'b0;
    clear_model();
    for (int i = 1; i < 16; i++) begin
      xfer(0, 1'b0, 32'(4 * i), 32'h0, 4'h0, rd, er, nw);
      n_checks++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL swrst_reg%0d got %h want 0", i, rd); end
    end
    xfer(1, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL swrst_dut1 got %h want 0", rd); end
    xfer(2, 1'b0, 32'h1014, 32'h0, 4'h0, rd, er, nw);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL swrst_midxfer got %h want 0", rd); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, wd; logic er; int nw;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      xfer(0, 1'b1, 32'(4 * i), wd, 4'hF, rd, er, nw);
      n_checks++;
      if (nw !== 0 || er !== (i == 0)) begin n_fail++; $display("FAIL b2b_write%0d waits=%0d err=%b", i, nw, er); end
      xfer(0, 1'b0, 32'(4 * i), 32'h0, 4'h0, rd, er, nw);
      n_checks++;
      if (nw !== 0 || rd !== ((i == 0) ? ID : wd)) begin
        n_fail++; $display("FAIL b2b_read%0d got %h waits=%0d want %h/0", i, rd, nw, (i == 0) ? ID : wd);
      end
    end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, a, erd; logic er, eer; int nw, d; bit wr;
    for (int k = 0; k < 80; k++) begin
      d = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      a = bases[d] + 32'($urandom_range(0, 79)) - 32'd8;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      eer = exp_err(d, wr, a);
      erd = exp_rd(d, a);
      xfer(d, wr, a, $urandom, 4'($urandom), rd, er, nw);
      n_checks++;
      if (er !== eer || nw !== waits[d] || (!wr && rd !== erd)) begin
        n_fail++; $display("FAIL rand%0d dut%0d wr=%b addr=%h got %h err=%b waits=%0d want %h err=%b waits=%0d",
                           k, d, wr, a, rd, er, nw, erd, eer, waits[d]);
      end
      if ($urandom_range(0, 1) != 0) idle();
    end
    idle();
    n_checks++;
    if (err_in_wait !== 0) begin n_fail++; $display("FAIL pslverr_while_waiting got %0d want 0", err_in_wait); end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_strobes();
    test_errors();
    test_abort();
    test_sw_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
